// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory loader
// Assembles big-endian words from a framed byte stream, writes them and verifies an XOR checksum.
module imem_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_written
);

  typedef enum logic [2:0] {
    IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERR
  } state_t;

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  localparam logic [31:0]         ADDR_MASK  = (32'd1 << (ADDR_WIDTH + 2)) - 32'd1;

  state_t                state, next_state;
  logic [ADDR_WIDTH:0]   n_words;
  logic [ADDR_WIDTH-1:0] word_index;
  logic [ADDR_WIDTH:0]   index_next;
  logic [1:0]            byte_cnt;
  logic [23:0]           shift_reg;
  logic [7:0]            csum;
  logic [31:0]           addr_sum;
  logic                  start_ok;

  assign start_ok   = start && (state == IDLE || state == DONE || state == ERR);
  assign index_next = {1'b0, word_index} + (ADDR_WIDTH+1)'(1);
  assign addr_sum   = BASE_ADDR + {{(30-ADDR_WIDTH){1'b0}}, word_index, 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    rx_ready   = 1'b0;
    imem_we    = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) next_state = COUNT;
      end
      COUNT: begin
        rx_ready = 1'b1;
        if (rx_valid) next_state = DATA;
      end
      DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_cnt == 2'd3) next_state = WRITE;
      end
      WRITE: begin
        imem_we    = 1'b1;
        next_state = (index_next == n_words) ? CHECK : DATA;
      end
      CHECK: begin
        rx_ready = 1'b1;
        if (rx_valid) next_state = (rx_data == csum) ? DONE : ERR;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_words       <= '0;
      word_index    <= '0;
      byte_cnt      <= '0;
      shift_reg     <= '0;
      csum          <= '0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      cpu_hold      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      if (start_ok) begin
        done          <= 1'b0;
        error         <= 1'b0;
        words_written <= '0;
        word_index    <= '0;
        byte_cnt      <= '0;
        csum          <= '0;
        cpu_hold      <= 1'b1;
        busy          <= 1'b1;
      end
      case (state)
        COUNT: begin
          if (rx_valid)
            n_words <= (rx_data == 8'd0) ? FULL_COUNT : (ADDR_WIDTH+1)'(rx_data);
        end
        DATA: begin
          if (rx_valid) begin
            shift_reg <= {shift_reg[15:0], rx_data};
            csum      <= csum ^ rx_data;
            byte_cnt  <= byte_cnt + 2'd1;
            // Address and data are registered here so they are stable during the WRITE cycle.
            if (byte_cnt == 2'd3) begin
              imem_wdata <= {shift_reg, rx_data};
              imem_addr  <= addr_sum & ADDR_MASK;
            end
          end
        end
        WRITE: begin
          // Full-memory frames wrap the index to 0 only here, after the last write.
          word_index    <= index_next[ADDR_WIDTH-1:0];
          words_written <= words_written + (ADDR_WIDTH+1)'(1);
        end
        CHECK: begin
          if (rx_valid) begin
            busy <= 1'b0;
            if (rx_data == csum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  words_written;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse is checked against the next expected {addr, data}.
  always @(negedge clk) begin
    if (imem_we) begin
      check("rx_ready_in_write", {63'd0, rx_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write", {imem_addr, imem_wdata}, mon_e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit throttle);
    int n;
    if (throttle) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_normal();
    exp_q.push_back({32'h0, 32'h2004_0005});
    exp_q.push_back({32'h4, 32'h0000_1026});
  endtask

  task automatic normal_frame(input logic [7:0] cs, input bit thr);
    logic [7:0] bytes [8];
    bytes = '{8'h20, 8'h04, 8'h00, 8'h05, 8'h00, 8'h00, 8'h10, 8'h26};
    push_normal();
    do_start();
    send_byte(8'h02, thr);
    for (int i = 0; i < 8; i++) send_byte(bytes[i], thr);
    send_byte(cs, thr);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic h, input logic [8:0] ww);
    check({tag, "_done"}, {63'd0, done}, {63'd0, d});
    check({tag, "_error"}, {63'd0, error}, {63'd0, e});
    check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, {63'd0, h});
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_words_written"}, {55'd0, words_written}, {55'd0, ww});
  endtask

  initial begin
    #1;
    check("reset_rx_ready", {63'd0, rx_ready}, 64'd0);
    check("reset_imem_we", {63'd0, imem_we}, 64'd0);
    check("reset_addr_data", {imem_addr, imem_wdata}, 64'd0);
    check("reset_flags", {60'd0, cpu_hold, busy, done, error}, 64'd0);
    check("reset_words_written", {55'd0, words_written}, 64'd0);
    #20 reset = 1'b1;
    @(posedge clk); #1;

    // start with a simultaneous byte offered: the byte must not be taken as the count
    push_normal();
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'h05;
    @(posedge clk); #1;
    start = 1'b0; rx_valid = 1'b0;
    check("start_busy", {62'd0, busy, cpu_hold}, 64'd3);
    begin
      logic [7:0] bytes [8];
      bytes = '{8'h20, 8'h04, 8'h00, 8'h05, 8'h00, 8'h00, 8'h10, 8'h26};
      send_byte(8'h02, 1'b0);
      for (int i = 0; i < 8; i++) send_byte(bytes[i], 1'b0);
      send_byte(8'h17, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    check_status("normal", 1'b1, 1'b0, 1'b0, 9'd2);

    normal_frame(8'h18, 1'b0);
    check_status("badcsum", 1'b0, 1'b1, 1'b1, 9'd2);
    normal_frame(8'h17, 1'b0);
    check_status("after_err", 1'b1, 1'b0, 1'b0, 9'd2);

    normal_frame(8'h17, 1'b1);
    check_status("throttled", 1'b1, 1'b0, 1'b0, 9'd2);

    // start pulsed mid-frame is ignored
    push_normal();
    do_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h04, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_mid_frame", {63'd0, busy}, 64'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h26, 1'b0);
    send_byte(8'h17, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_status("start_ignored", 1'b1, 1'b0, 1'b0, 9'd2);

    // full memory: word i = i, XOR of 0..255 is 0
    for (int i = 0; i < 256; i++) exp_q.push_back({i * 4, i});
    do_start();
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(i[7:0], 1'b0);
    end
    send_byte(8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_status("full", 1'b1, 1'b0, 1'b0, 9'd256);
    check("full_last_addr", {32'd0, imem_addr}, 64'h3FC);

    // reset mid-frame after the 6th data byte
    exp_q.push_back({32'h0, 32'h2004_0005});
    do_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("midreset_rx_ready_we", {62'd0, rx_ready, imem_we}, 64'd0);
    check("midreset_addr_data", {imem_addr, imem_wdata}, 64'd0);
    check("midreset_flags", {60'd0, cpu_hold, busy, done, error}, 64'd0);
    check("midreset_words_written", {55'd0, words_written}, 64'd0);
    check("midreset_writes_done", exp_q.size(), 64'd0);
    #10 reset = 1'b1;
    @(posedge clk); #1;
    normal_frame(8'h17, 1'b0);
    check_status("after_reset", 1'b1, 1'b0, 1'b0, 9'd2);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory. It receives a framed byte stream over a valid/ready interface and assembles big-endian 32-bit instruction words. It drives the instruction memory's write port word by word and verifies an XOR checksum. While loading, it holds the pipeline CPU stalled so the CPU only fetches a fully written program.

Parameters:
ADDR_WIDTH, 8, word-index width; the memory holds 2^ADDR_WIDTH words, indexed by byte address bits [ADDR_WIDTH+1:2].
BASE_ADDR, 32'h0000_0000, byte address of the first written word; word-aligned.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset: reset=0 clears all state immediately.
start  input  1  single-cycle request to begin a load frame.
rx_valid  input  1  byte source has a byte on rx_data.
rx_data  input  8  stream byte.
rx_ready  output  1  loader accepts rx_data this cycle.
imem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
imem_addr  output  32  byte address of the write; bits [1:0] are always 0.
imem_wdata  output  32  instruction word to write.
cpu_hold  output  1  stalls the CPU (PC and fetch) while 1.
busy  output  1  a frame is in progress.
done  output  1  sticky: the last frame completed with a good checksum.
error  output  1  sticky: the last frame failed its checksum.
words_written  output  ADDR_WIDTH+1  count of words written in the current or last frame.

Behaviour:
- Frame format: count byte N, then 4*N data bytes, then one checksum byte.
  - N=0 means 2^ADDR_WIDTH words.
  - Data bytes are MSB first: the first byte goes to bits [31:24].
  - Checksum = XOR of all data bytes. The count byte is excluded.
- Handshake: a byte transfers on a rising edge with rx_valid && rx_ready. Gaps in rx_valid are allowed anywhere. rx_data is ignored when no transfer occurs.
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, busy=0, done=0, error=0, words_written=0. All counters and the checksum accumulator are 0. The FSM is in IDLE.
- FSM states: IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERR.
- IDLE, DONE or ERR with start=1: go to COUNT.
  - Clear done, error, words_written, the word index and the checksum accumulator.
  - Set cpu_hold=1 and busy=1 from the next cycle.
- start while busy is ignored.
- COUNT: rx_ready=1. On a transfer, latch N (0 maps to 2^ADDR_WIDTH) and go to DATA.
- DATA: rx_ready=1.
  - Each transfer shifts the byte into the word register, XORs it into the checksum and increments the byte counter (0..3).
  - On the 4th byte, go to WRITE.
- WRITE (exactly one cycle): rx_ready=0, imem_we=1.
  - imem_addr = BASE_ADDR + (word_index << 2), kept to ADDR_WIDTH+2 bits then zero-extended.
  - imem_wdata = the assembled word.
  - Next edge: word_index++ and words_written++. Go to CHECK if the incremented index equals N, else to DATA.
  - Write latency: imem_we asserts the cycle after the 4th-byte handshake.
- CHECK: rx_ready=1. On a transfer, compare the byte with the accumulator.
  - Equal: go to DONE (done=1, busy=0, cpu_hold=0).
  - Not equal: go to ERR (error=1, busy=0, cpu_hold stays 1).
- Outside WRITE: imem_we=0; imem_addr and imem_wdata hold their last values.
- Full-memory frame (N = 2^ADDR_WIDTH): the word index wraps to 0 only after the final write. No extra write occurs, and words_written reaches 2^ADDR_WIDTH without overflow.
- Reset asserted mid-frame: return to the reset state at once. Any imem_we in flight is dropped, and words already written stay in memory.
- start and a byte transfer in the same cycle while in IDLE: the byte is not consumed (rx_ready=0 in IDLE).

Test Plan:
- Normal load: start, then bytes 02, 20 04 00 05, 00 00 10 26, checksum 17 -> two imem_we pulses: addr 0x0 data 0x20040005, addr 0x4 data 0x00001026; done=1, cpu_hold=0, words_written=2.
- Bad checksum: same frame with checksum 0x18 -> both writes occur, error=1, done=0, cpu_hold remains 1; a new start then loads correctly.
- Throttled source: the normal frame with rx_valid low every other cycle -> same writes and data; rx_ready=0 during each WRITE cycle; no byte lost or duplicated.
- Full memory: N=00 with 1024 data bytes (word i = i) and the correct checksum -> 256 writes, last at addr 0x3FC, words_written=256, done=1.
- start during busy: start pulsed while in DATA -> ignored; the frame completes normally.
- Reset mid-frame: reset=0 after the 6th data byte -> all outputs return to reset values asynchronously; only word 0 was written; a subsequent full frame succeeds.
